// File: rtl/multicycle_main_fsm.sv
// multicycle_main_fsm: main control FSM for the multicycle ARM datapath.
// Define ILLEGAL_TRAP_EN to trap on undefined (Op=11) instructions.
module multicycle_main_fsm #(
  parameter int MEM_LAT = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic       ALUOp,
  output logic       NextPC,
  output logic       RegW,
  output logic       MemW,
  output logic       Branch,
  output logic       Trap,
  output logic [3:0] State
);

  localparam int CW = (MEM_LAT < 1) ? 1 : $clog2(MEM_LAT + 1);
  localparam logic [CW-1:0] LAT = CW'(MEM_LAT);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    TRAP     = 4'd10
  } state_t;

  state_t        st, nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          done;
  logic          wait_st;
  logic          unused;

  assign unused = ^Funct[4:1];
  assign done   = (cnt == '0);
  assign State  = st;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st  <= FETCH;
      cnt <= LAT;
    end else begin
      st  <= nxt;
      cnt <= cnt_nxt;
    end
  end

  always_comb begin
    nxt = FETCH;
    unique case (st)
      FETCH:  nxt = done ? DECODE : FETCH;
      DECODE: begin
        unique case (1'b1)
          Op == 2'b01:              nxt = MEMADR;
          Op == 2'b00 && !Funct[5]: nxt = EXECUTER;
          Op == 2'b00 && Funct[5]:  nxt = EXECUTEI;
          Op == 2'b10:              nxt = BRANCH;
          default: begin
`ifdef ILLEGAL_TRAP_EN
            nxt = TRAP;
`else
            nxt = FETCH;
`endif
          end
        endcase
      end
      MEMADR:   nxt = Funct[0] ? MEMRD : MEMWR;
      MEMRD:    nxt = done ? MEMWB : MEMRD;
      MEMWB:    nxt = FETCH;
      MEMWR:    nxt = done ? FETCH : MEMWR;
      EXECUTER: nxt = ALUWB;
      EXECUTEI: nxt = ALUWB;
      ALUWB:    nxt = FETCH;
      BRANCH:   nxt = FETCH;
`ifdef ILLEGAL_TRAP_EN
      TRAP:     nxt = TRAP;
`endif
      default:  nxt = FETCH;
    endcase
  end

  // Counter reloads only when entering a wait state from another state.
  always_comb begin
    wait_st = (nxt == FETCH) || (nxt == MEMRD) || (nxt == MEMWR);
    cnt_nxt = cnt;
    if (nxt != st && wait_st)
      cnt_nxt = LAT;
    else if (!done)
      cnt_nxt = cnt - 1'b1;
  end

  always_comb begin
    IRWrite   = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 2'b00;
    ResultSrc = 2'b00;
    ALUOp     = 1'b0;
    NextPC    = 1'b0;
    RegW      = 1'b0;
    MemW      = 1'b0;
    Branch    = 1'b0;
    Trap      = 1'b0;
    unique case (st)
      FETCH: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = done;
        NextPC    = done;
      end
      DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      MEMADR: ALUSrcB = 2'b01;
      MEMRD:  AdrSrc = 1'b1;
      MEMWB: begin
        ResultSrc = 2'b01;
        RegW      = 1'b1;
      end
      MEMWR: begin
        AdrSrc = 1'b1;
        MemW   = done;
      end
      EXECUTER: ALUOp = 1'b1;
      EXECUTEI: begin
        ALUSrcB = 2'b01;
        ALUOp   = 1'b1;
      end
      ALUWB: RegW = 1'b1;
      BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        Branch    = 1'b1;
      end
`ifdef ILLEGAL_TRAP_EN
      TRAP: Trap = 1'b1;
`endif
      default: ;
    endcase
    if (!reset) begin
      IRWrite   = 1'b0;
      AdrSrc    = 1'b0;
      ALUSrcA   = 1'b0;
      ALUSrcB   = 2'b00;
      ResultSrc = 2'b00;
      ALUOp     = 1'b0;
      NextPC    = 1'b0;
      RegW      = 1'b0;
      MemW      = 1'b0;
      Branch    = 1'b0;
      Trap      = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_main_fsm.sv
// tb_multicycle_main_fsm: checks two FSM instances (MEM_LAT 0 and 2)
// against a per-instruction cycle-trace model.
module tb_multicycle_main_fsm;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       r0, r2;
  logic [1:0] op0, op2;
  logic [5:0] f0, f2;

  logic       irw0, adr0, asa0, aop0, npc0, rw0, mw0, br0, tr0;
  logic [1:0] asb0, rs0;
  logic [3:0] st0;
  logic       irw2, adr2, asa2, aop2, npc2, rw2, mw2, br2, tr2;
  logic [1:0] asb2, rs2;
  logic [3:0] st2;

  logic [16:0] obs0, obs2;
  assign obs0 = {st0, irw0, adr0, asa0, asb0, rs0, aop0,
                 npc0, rw0, mw0, br0, tr0};
  assign obs2 = {st2, irw2, adr2, asa2, asb2, rs2, aop2,
                 npc2, rw2, mw2, br2, tr2};

  multicycle_main_fsm #(.MEM_LAT(0)) dut0 (
    .clk(clk), .reset(r0), .Op(op0), .Funct(f0),
    .IRWrite(irw0), .AdrSrc(adr0), .ALUSrcA(asa0),
    .ALUSrcB(asb0), .ResultSrc(rs0), .ALUOp(aop0),
    .NextPC(npc0), .RegW(rw0), .MemW(mw0),
    .Branch(br0), .Trap(tr0), .State(st0)
  );

  multicycle_main_fsm #(.MEM_LAT(2)) dut2 (
    .clk(clk), .reset(r2), .Op(op2), .Funct(f2),
    .IRWrite(irw2), .AdrSrc(adr2), .ALUSrcA(asa2),
    .ALUSrcB(asb2), .ResultSrc(rs2), .ALUOp(aop2),
    .NextPC(npc2), .RegW(rw2), .MemW(mw2),
    .Branch(br2), .Trap(tr2), .State(st2)
  );

  int total = 0;
  int bad   = 0;
  logic [16:0] q[$];

  // Expected outputs for one cycle spent in state s.
  function automatic logic [16:0] pv(int s, bit last);
    logic irw, adr, asa, aop, npc, rw, mw, br, tr;
    logic [1:0] asb, rs;
    {irw, adr, asa, aop, npc, rw, mw, br, tr} = '0;
    asb = 2'b00;
    rs  = 2'b00;
    case (s)
      0: begin asa = 1; asb = 2; rs = 2; irw = last; npc = last; end
      1: begin asa = 1; asb = 2; rs = 2; end
      2: asb = 1;
      3: adr = 1;
      4: begin rs = 1; rw = 1; end
      5: begin adr = 1; mw = last; end
      6: aop = 1;
      7: begin asb = 1; aop = 1; end
      8: rw = 1;
      9: begin asb = 1; rs = 2; br = 1; end
      10: tr = 1;
      default: ;
    endcase
    return {4'(s), irw, adr, asa, asb, rs, aop, npc, rw, mw, br, tr};
  endfunction

  // Whole-instruction trace: one entry per clock cycle.
  task automatic build(int lat, logic [1:0] op, logic [5:0] fn);
    q.delete();
    for (int i = 0; i <= lat; i++) q.push_back(pv(0, i == lat));
    q.push_back(pv(1, 0));
    case (op)
      2'b00: begin
        q.push_back(pv(fn[5] ? 7 : 6, 0));
        q.push_back(pv(8, 0));
      end
      2'b01: begin
        q.push_back(pv(2, 0));
        if (fn[0]) begin
          for (int i = 0; i <= lat; i++) q.push_back(pv(3, 0));
          q.push_back(pv(4, 0));
        end else begin
          for (int i = 0; i <= lat; i++) q.push_back(pv(5, i == lat));
        end
      end
      2'b10: q.push_back(pv(9, 0));
      default: ;
    endcase
  endtask

  task automatic check(int d, logic [16:0] exp, string tag, int i);
    logic [16:0] obs;
    obs = (d == 0) ? obs0 : obs2;
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s dut%0d step %0d: got %h want %h",
             tag, d, i, obs, exp);
    end
  endtask

  task automatic run(int d, logic [1:0] op, logic [5:0] fn,
                     int lim, string tag);
    if (d == 0) begin op0 = op; f0 = fn; end
    else        begin op2 = op; f2 = fn; end
    build((d == 0) ? 0 : 2, op, fn);
    for (int i = 0; i < q.size() && i < lim; i++) begin
      check(d, q[i], tag, i);
      @(negedge clk); #1;
    end
  endtask

  task automatic resync(int d, string tag);
    if (d == 0) r0 = 1'b0; else r2 = 1'b0;
    #1;
    check(d, 17'h0, tag, 0);
    @(negedge clk); #1;
    check(d, 17'h0, tag, 1);
    if (d == 0) r0 = 1'b1; else r2 = 1'b1;
    #1;
  endtask

  logic [1:0] rop;
  logic [5:0] rfn;

  initial begin
    r0 = 1'b0; r2 = 1'b0;
    op0 = 2'b00; op2 = 2'b00;
    f0 = 6'h0; f2 = 6'h0;
    @(negedge clk); #1;

    resync(0, "reset0");
    run(0, 2'b00, 6'b101000, 100, "add_imm");
    run(0, 2'b00, 6'b001000, 100, "add_reg");
    run(0, 2'b01, 6'b011001, 100, "ldr");
    run(0, 2'b01, 6'b011000, 100, "str");
    run(0, 2'b10, 6'b000000, 100, "branch");
`ifdef ILLEGAL_TRAP_EN
    run(0, 2'b11, 6'h00, 2, "trap_entry");
    for (int i = 0; i < 22; i++) begin
      check(0, pv(10, 0), "trap_hold", i);
      @(negedge clk); #1;
    end
    resync(0, "trap_reset");
`else
    run(0, 2'b11, 6'h3f, 100, "undef_nop");
`endif
    for (int n = 0; n < 25; n++) begin
      rop = 2'($urandom_range(0, 3));
`ifdef ILLEGAL_TRAP_EN
      if (rop == 2'b11) rop = 2'b00;
`endif
      rfn = 6'($urandom);
      run(0, rop, rfn, 100, "rand0");
    end

    resync(2, "reset2");
    run(2, 2'b01, 6'b011000, 100, "str_lat2");
    run(2, 2'b01, 6'b011001, 100, "ldr_lat2");
    run(2, 2'b01, 6'b011000, 6, "str_abort");
    check(2, pv(5, 0), "memwr_wait", 0);
    r2 = 1'b0; #1;
    check(2, 17'h0, "abort_rst", 0);
    @(negedge clk); #1;
    check(2, 17'h0, "abort_rst", 1);
    r2 = 1'b1; #1;
    run(2, 2'b10, 6'h00, 100, "post_abort");
    for (int n = 0; n < 15; n++) begin
      rop = 2'($urandom_range(0, 3));
`ifdef ILLEGAL_TRAP_EN
      if (rop == 2'b11) rop = 2'b10;
`endif
      rfn = 6'($urandom);
      run(2, rop, rfn, 100, "rand2");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
